// File: rtl/dff_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : dff_shift_reg
// Brief    : WIDTH-bit hold / shift-right / shift-left / load register with
//            serial I/O, optional rotate and a word-shift counter.
// Revision : 1.0 - initial release
// ============================================================================
module dff_shift_reg #(
    parameter int              WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}},
    parameter bit              ROTATE      = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic                       ser_in,
    input  logic [WIDTH-1:0]           data,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           qbar,
    output logic                       ser_out,
    output logic [$clog2(WIDTH+1)-1:0] shift_cnt,
    output logic                       done
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    localparam logic [1:0]       c_MODE_HOLD  = 2'b00;
    localparam logic [1:0]       c_MODE_SHR   = 2'b01;
    localparam logic [1:0]       c_MODE_SHL   = 2'b10;
    localparam logic [1:0]       c_MODE_LOAD  = 2'b11;
    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    generate
        if (WIDTH < 2) begin : g_width_check
            $error("dff_shift_reg: WIDTH must be 2 or more");
        end
    endgenerate

    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_done;

    logic             w_fill_right;
    logic             w_fill_left;
    logic [WIDTH-1:0] w_shr;
    logic [WIDTH-1:0] w_shl;

    // Vacated bit comes from the opposite end when rotating, else from ser_in.
    generate
        if (ROTATE) begin : g_rotate
            assign w_fill_right = r_q[0];
            assign w_fill_left  = r_q[WIDTH-1];
        end else begin : g_fill
            assign w_fill_right = ser_in;
            assign w_fill_left  = ser_in;
        end
    endgenerate

    assign w_shr = {w_fill_right, r_q[WIDTH-1:1]};
    assign w_shl = {r_q[WIDTH-2:0], w_fill_left};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q    <= RESET_VALUE;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (en) begin
                case (mode)
                    c_MODE_LOAD: begin
                        r_q   <= data;
                        r_cnt <= '0;
                    end
                    c_MODE_SHR, c_MODE_SHL: begin
                        r_q <= (mode == c_MODE_SHR) ? w_shr : w_shl;
                        // Direction changes do not restart the word count.
                        if (r_cnt == c_CNT_LAST) begin
                            r_cnt  <= '0;
                            r_done <= 1'b1;
                        end else begin
                            r_cnt  <= r_cnt + c_CNT_ONE;
                        end
                    end
                    c_MODE_HOLD: begin
                        r_q   <= r_q;
                        r_cnt <= r_cnt;
                    end
                    default: begin
                        r_q   <= r_q;
                        r_cnt <= r_cnt;
                    end
                endcase
            end
        end
    end

    assign q         = r_q;
    assign qbar      = ~r_q;
    assign ser_out   = (mode == c_MODE_SHR) ? r_q[0] : r_q[WIDTH-1];
    assign shift_cnt = r_cnt;
    assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dff_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_dff_shift_reg
// Brief    : Directed self-checking bench; one shift-fill and one rotate DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dff_shift_reg;

    logic       clk;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic       ser_in;
    logic [7:0] data;

    logic [7:0] q0, qbar0, q1, qbar1;
    logic       so0, so1, done0, done1;
    logic [3:0] cnt0, cnt1;

    int n_pass;
    int n_total;

    dff_shift_reg #(.WIDTH(8), .RESET_VALUE(8'hA5), .ROTATE(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .ser_in(ser_in),
        .data(data), .q(q0), .qbar(qbar0), .ser_out(so0),
        .shift_cnt(cnt0), .done(done0)
    );

    dff_shift_reg #(.WIDTH(8), .RESET_VALUE(8'hA5), .ROTATE(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .en(en), .mode(mode), .ser_in(ser_in),
        .data(data), .q(q1), .qbar(qbar1), .ser_out(so1),
        .shift_cnt(cnt1), .done(done1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; en = 1'b1; mode = 2'b11; data = 8'h00; ser_in = 1'b0;
        step();
        n_total++;
        if (q0 !== 8'h00) $display("FAIL pre_reset_load: q=%h expected %h", q0, 8'h00);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if (q0 !== 8'hA5) $display("FAIL reset_q: q=%h expected %h", q0, 8'hA5);
        else n_pass++;
        n_total++;
        if (qbar0 !== 8'h5A) $display("FAIL reset_qbar: qbar=%h expected %h", qbar0, 8'h5A);
        else n_pass++;
        n_total++;
        if (cnt0 !== 4'd0 || done0 !== 1'b0)
            $display("FAIL reset_cnt_done: cnt=%0d done=%b expected 0/0", cnt0, done0);
        else n_pass++;
        step();
        n_total++;
        if (q0 !== 8'hA5) $display("FAIL reset_held: q=%h expected %h", q0, 8'hA5);
        else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_load_hold();
        en = 1'b1; mode = 2'b11; data = 8'h3C;
        step();
        mode = 2'b00; data = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (q0 !== 8'h3C || qbar0 !== 8'hC3 || cnt0 !== 4'd0)
                $display("FAIL load_hold[%0d]: q=%h qbar=%h cnt=%0d expected 3c/c3/0",
                         i, q0, qbar0, cnt0);
            else n_pass++;
            step();
        end
    endtask

    task automatic test_shift_right();
        logic [7:0] exp_q;
        logic [7:0] ser_exp;
        ser_exp = 8'b1000_0001;
        exp_q   = 8'h81;
        mode = 2'b11; data = 8'h81;
        step();
        mode = 2'b01; ser_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (so0 !== ser_exp[7-i])
                $display("FAIL shr_ser_out[%0d]: got %b expected %b", i, so0, ser_exp[7-i]);
            else n_pass++;
            step();
            exp_q = {1'b0, exp_q[7:1]};
            n_total++;
            if (q0 !== exp_q || done0 !== (i == 7) || cnt0 !== 4'((i + 1) % 8))
                $display("FAIL shr_edge[%0d]: q=%h done=%b cnt=%0d expected %h/%b/%0d",
                         i, q0, done0, cnt0, exp_q, (i == 7), (i + 1) % 8);
            else n_pass++;
        end
        n_total++;
        if (q0 !== 8'h00) $display("FAIL shr_final: q=%h expected 00", q0);
        else n_pass++;
        mode = 2'b00;
        step();
        n_total++;
        if (done0 !== 1'b0) $display("FAIL shr_done_clear: done=%b expected 0", done0);
        else n_pass++;
    endtask

    task automatic test_left_rotate();
        mode = 2'b11; data = 8'h80;
        step();
        mode = 2'b10; ser_in = 1'b1;
        n_total++;
        if (so1 !== 1'b1) $display("FAIL shl_ser_out: got %b expected 1", so1);
        else n_pass++;
        step();
        n_total++;
        if (q1 !== 8'h01 || q0 !== 8'h01 || cnt1 !== 4'd1)
            $display("FAIL shl_first: rot=%h fill=%h cnt=%0d expected 01/01/1", q1, q0, cnt1);
        else n_pass++;
        for (int i = 0; i < 7; i++) begin
            step();
            n_total++;
            if (done1 !== (i == 6))
                $display("FAIL rot_done[%0d]: got %b expected %b", i, done1, (i == 6));
            else n_pass++;
        end
        n_total++;
        if (q1 !== 8'h80 || cnt1 !== 4'd0)
            $display("FAIL rot_final: q=%h cnt=%0d expected 80/0", q1, cnt1);
        else n_pass++;
        n_total++;
        if (q0 !== 8'hFF) $display("FAIL shl_fill_final: q=%h expected ff", q0);
        else n_pass++;
    endtask

    task automatic test_enable();
        mode = 2'b11; data = 8'h0F;
        step();
        mode = 2'b01; ser_in = 1'b1;
        step(); step(); step();
        n_total++;
        if (q0 !== 8'hE1 || cnt0 !== 4'd3)
            $display("FAIL en_pre: q=%h cnt=%0d expected e1/3", q0, cnt0);
        else n_pass++;
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_total++;
            if (q0 !== 8'hE1 || cnt0 !== 4'd3 || done0 !== 1'b0)
                $display("FAIL en_gated[%0d]: q=%h cnt=%0d done=%b expected e1/3/0",
                         i, q0, cnt0, done0);
            else n_pass++;
        end
        en = 1'b1;
        step();
        n_total++;
        if (cnt0 !== 4'd4 || q0 !== 8'hF0)
            $display("FAIL en_resume: q=%h cnt=%0d expected f0/4", q0, cnt0);
        else n_pass++;
        step(); step(); step();
        n_total++;
        if (done0 !== 1'b0 || cnt0 !== 4'd7)
            $display("FAIL en_pre_wrap: done=%b cnt=%0d expected 0/7", done0, cnt0);
        else n_pass++;
        step();
        n_total++;
        if (done0 !== 1'b1 || cnt0 !== 4'd0 || q0 !== 8'hFF)
            $display("FAIL en_wrap: done=%b cnt=%0d q=%h expected 1/0/ff", done0, cnt0, q0);
        else n_pass++;
    endtask

    task automatic test_load_priority();
        mode = 2'b11; data = 8'h00;
        step();
        mode = 2'b01;
        for (int i = 0; i < 4; i++) step();
        mode = 2'b10;
        for (int i = 0; i < 3; i++) step();
        n_total++;
        if (cnt0 !== 4'd7) $display("FAIL mixed_dir_cnt: cnt=%0d expected 7", cnt0);
        else n_pass++;
        mode = 2'b11; data = 8'h5A;
        step();
        n_total++;
        if (done0 !== 1'b0 || cnt0 !== 4'd0 || q0 !== 8'h5A)
            $display("FAIL load_priority: done=%b cnt=%0d q=%h expected 0/0/5a",
                     done0, cnt0, q0);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int pulses;
        pulses = 0;
        mode = 2'b10; ser_in = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            if (done1 === 1'b1) pulses++;
            if (i == 7 || i == 15) begin
                n_total++;
                if (done1 !== 1'b1) $display("FAIL b2b_done[%0d]: got %b expected 1", i, done1);
                else n_pass++;
            end
        end
        n_total++;
        if (pulses != 2) $display("FAIL b2b_pulses: got %0d expected 2", pulses);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        mode = 2'b11; data = 8'h33;
        step();
        mode = 2'b01;
        for (int i = 0; i < 7; i++) step();
        n_total++;
        if (cnt0 !== 4'd7) $display("FAIL rst_mid_pre: cnt=%0d expected 7", cnt0);
        else n_pass++;
        #2 reset = 1'b0;
        #1;
        n_total++;
        if (q0 !== 8'hA5 || cnt0 !== 4'd0 || done0 !== 1'b0)
            $display("FAIL rst_mid: q=%h cnt=%0d done=%b expected a5/0/0", q0, cnt0, done0);
        else n_pass++;
        step();
        reset = 1'b1;
        step();
        n_total++;
        if (done0 !== 1'b0 || cnt0 !== 4'd1 || q0 !== 8'h52)
            $display("FAIL rst_release: done=%b cnt=%0d q=%h expected 0/1/52",
                     done0, cnt0, q0);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        reset = 1'b1; en = 1'b0; mode = 2'b00; ser_in = 1'b0; data = 8'h00;
        test_reset();
        test_load_hold();
        test_shift_right();
        test_left_rotate();
        test_enable();
        test_load_priority();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dff_shift_reg.md
Name: dff_shift_reg

Overview:
- Parametrised successor to the team's single-bit asynchronous D flip-flop.
- WIDTH-bit register with four modes:
  - hold
  - shift-right
  - shift-left
  - parallel load
- Other features:
  - optional rotate and configurable reset value
  - complementary output
  - serial in/out
  - shift counter that pulses `done` when a full word has been shifted since the last load
- Used as a general storage/serialiser cell in later lab designs.

Parameters:
- WIDTH, 8, register width in bits; legal range is 2 or more.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q on reset.
- ROTATE, 0, 1 = shifts wrap internally and ser_in is ignored; 0 = ser_in fills the vacated bit.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- en  input  1  clock enable; 0 holds all state
- mode  input  2  00 hold, 01 shift right, 10 shift left, 11 load
- ser_in  input  1  serial data into the vacated bit
- data  input  WIDTH  parallel load value
- q  output  WIDTH  register contents
- qbar  output  WIDTH  bitwise complement of q, combinational
- ser_out  output  1  serial output, combinational: q[0] when mode==01, otherwise q[WIDTH-1]
- shift_cnt  output  $clog2(WIDTH+1)  number of shifts since the last load or reset
- done  output  1  one-cycle pulse after the WIDTH-th shift

Behaviour:
- Reset (reset==0, asynchronous, immediate, independent of clk):
  - q=RESET_VALUE, so qbar=~RESET_VALUE
  - shift_cnt=0, done=0
- Reset deassertion is sampled at the next rising clk edge; no operation occurs on the deasserting edge unless reset is already high before that edge.
- All state updates happen on the rising clk edge, and only when reset==1.
- en==0: q and shift_cnt hold; done is driven to 0 on that edge.
- en==1, mode==00 (hold): q and shift_cnt hold; done=0.
- en==1, mode==11 (load): q<=data, shift_cnt<=0, done=0.
- en==1, mode==01 (shift right):
  - ROTATE=0: q<={ser_in, q[WIDTH-1:1]}
  - ROTATE=1: q<={q[0], q[WIDTH-1:1]}
- en==1, mode==10 (shift left):
  - ROTATE=0: q<={q[WIDTH-2:0], ser_in}
  - ROTATE=1: q<={q[WIDTH-2:0], q[WIDTH-1]}
- Shift counter, on any shift edge:
  - If shift_cnt==WIDTH-1: shift_cnt<=0 and done<=1 on the same edge. done is high for exactly one cycle, then returns to 0 on the next edge unless the counter wraps again.
  - Otherwise: shift_cnt<=shift_cnt+1 and done<=0.
- Changing direction mid-word does not reset the counter; each shift counts the same regardless of direction.
- A load on the edge where shift_cnt==WIDTH-1 takes priority: the counter clears and no done pulse is produced.
- Latency:
  - q is valid one cycle after the operation is sampled.
  - qbar, ser_out and done have no further delay beyond q.
- done and shift_cnt are never X after reset; unknown mode values are treated as hold.

Test Plan:
- Reset: WIDTH=8, RESET_VALUE=8'hA5, reset=0 mid-cycle → q=8'hA5 and qbar=8'h5A immediately with no clk edge; shift_cnt=0, done=0.
- Load then hold: reset=1, en=1, mode=11, data=8'h3C for one edge, then mode=00 for three edges → q=8'h3C throughout, qbar=8'hC3, shift_cnt=0.
- Right-shift serialise: after loading 8'h81, mode=01, ser_in=0 for 8 edges →
  - ser_out sequence 1,0,0,0,0,0,0,1
  - q=8'h00 at the end
  - done high only after the 8th edge
  - shift_cnt returns to 0
- Left rotate: ROTATE=1, load 8'h80, mode=10 for 1 edge → q=8'h01; continue 7 more edges → q=8'h80 and done pulses once.
- Enable gating: mid-word with shift_cnt=3, set en=0 for 4 edges → q and shift_cnt unchanged, done=0; re-enable → counting resumes from 3.
- Reset mid-operation: with shift_cnt=7, pull reset=0 between edges → q=RESET_VALUE, shift_cnt=0 and done=0 immediately; no done pulse after release.
